serving_timer: RTL
==================

// Module: serving_timer
// PURPOSE
//  Wishbone responder on the serving external bus (o_wb_* / i_wb_rdt / i_wb_ack) that implements a
//  RISC-V style machine timer: 64-bit mtime, 64-bit mtimecmp, prescaler, enable.
//  Its o_timer_irq drives serving.i_timer_irq. It answers every access to its 32-byte window.
// PARAMETERS
//  PRESCALE_W  16  width of prescaler counter/reload register
//  RESET_PRE   0   reset value of PRESCALE reg (0 = mtime increments every enabled clock)
// PORTS
//  i_clk         in   1   system clock
//  i_rst         in   1   synchronous, active-high reset
//  i_wb_adr      in   3   word address, bus address bits [4:2]
//  i_wb_dat      in   32  write data
//  i_wb_sel      in   4   byte enables, writes only
//  i_wb_we       in   1   1 = write
//  i_wb_stb      in   1   request; held by initiator until ack
//  o_wb_rdt      out  32  read data, valid in ack cycle
//  o_wb_ack      out  1   one-cycle acknowledge
//  o_timer_irq   out  1   level interrupt to core
// BEHAVIOUR
//  Reg map (adr): 0 MTIME_LO, 1 MTIME_HI, 2 CMP_LO, 3 CMP_HI, 4 CTRL(bit0 EN), 5 PRESCALE,
//   6-7 reserved: read 0, writes ignored, still acked.
//  Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=0, PRESCALE=RESET_PRE, prescaler cnt=0,
//   hi shadow=0, o_wb_ack=0, o_wb_rdt=0, o_timer_irq=0. Reset mid-transfer: ack dropped, write discarded.
//  Handshake: o_wb_ack <= i_wb_stb & ~o_wb_ack. Ack 1 cycle after stb seen, exactly 1 cycle wide.
//   Back-to-back stb gives ack every other cycle. Write side effects commit in the ack cycle edge
//   (same edge that raises ack). o_wb_rdt registered alongside ack; it holds its value otherwise.
//  Writes honour i_wb_sel per byte; sel=0 write is acked with no effect.
//  Read atomicity: reading MTIME_LO returns mtime[31:0] and latches mtime[63:32] into hi shadow.
//   Reading MTIME_HI returns the shadow, not live mtime. Shadow is updated only by MTIME_LO reads.
//  Prescaler: when EN=1, cnt increments each clock. When cnt==PRESCALE: cnt<=0, tick=1 for one clock.
//   When EN=0: cnt held, no ticks.
//   Writing PRESCALE also clears cnt. Writing CTRL with EN=0 does not clear mtime.
//  mtime: +1 per tick, 64-bit wrap FFFF..FFFF -> 0.
//   A bus write to MTIME_LO/HI in the same cycle as a tick wins. Only the written bytes take bus data;
//   the other half keeps its pre-tick value, so no increment is applied that cycle.
//  IRQ: o_timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare, registered, one cycle after the
//   operands change. EN does not gate the IRQ.
//   Level, no sticky state: software clears by raising CMP or lowering mtime.
//   Writing CMP_LO then CMP_HI may glitch the IRQ between the two writes; software writes CMP_HI=FFFFFFFF first.
// STRUCTURE
//  serving_timer_defs.vh: localparams for register word addresses (TMR_MTIME_LO..TMR_PRESCALE) and
//   CTRL bit index; shared with firmware header generation.
//  Sub-module serving_timer_prescaler (EN, reload value, clear -> tick); remainder is one flat module.
//  Integration: ext bus decode is outside this block; stb is qualified by the decode before reaching it.
// TESTING
//  1 Reset, read all 8 words -> 0,0,FFFFFFFF,FFFFFFFF,0,RESET_PRE,0,0; irq=0; each ack 1 cycle after stb.
//  2 PRESCALE=3, CTRL=1, wait 40 clk, read MTIME_LO -> 10 (+/-1 for bus latency);
//    hold stb high 6 clk -> 3 single-cycle acks.
//  3 mtime=0x0000_0000_FFFF_FFFE, EN=1, PRESCALE=0; after 3 ticks read LO then HI -> 0x00000001, 0x00000001;
//    read HI again after further ticks -> same shadow value.
//  4 mtimecmp=5, mtime=0, EN=1, PRESCALE=0 -> irq rises 1 clk after mtime reaches 5;
//    write CMP_HI=1 -> irq falls next clk.
//  5 Write MTIME_LO, sel=4'b0010, dat=0xAABBCCDD on a tick cycle -> mtime[15:8]=CC, other bytes keep
//    pre-tick value; sel=0 write -> acked, no change.
//  6 Assert i_rst in the cycle after stb of a CMP_LO write -> no ack, CMP remains all ones, irq=0.

Source files
------------

// File: rtl/serving_timer_pkg.sv
// Shared register map, bus widths and byte-lane merge helper for the serving machine timer.
package serving_timer_pkg;

  localparam int unsigned WB_DW  = 32;
  localparam int unsigned WB_AW  = 3;
  localparam int unsigned WB_SW  = 4;
  localparam int unsigned TIME_W = 64;

  localparam logic [WB_AW-1:0] TMR_MTIME_LO = 3'd0;
  localparam logic [WB_AW-1:0] TMR_MTIME_HI = 3'd1;
  localparam logic [WB_AW-1:0] TMR_CMP_LO   = 3'd2;
  localparam logic [WB_AW-1:0] TMR_CMP_HI   = 3'd3;
  localparam logic [WB_AW-1:0] TMR_CTRL     = 3'd4;
  localparam logic [WB_AW-1:0] TMR_PRESCALE = 3'd5;

  localparam int unsigned TMR_CTRL_EN = 0;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [WB_DW-1:0] wb_merge(input logic [WB_DW-1:0] old_v,
                                                 input logic [WB_DW-1:0] dat,
                                                 input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] merged;
    merged = old_v;
    for (int i = 0; i < int'(WB_SW); i++) begin
      if (sel[i]) merged[8*i +: 8] = dat[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/serving_timer_prescaler.sv
// Free-running reload prescaler: emits a one-clock tick each time the count reaches the reload value.
module serving_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_reload,
  input  logic                  i_clear,
  output logic                  o_tick_c
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  assign o_tick_c = i_en & (cnt_q == i_reload);

  // A reload write restarts the count even while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = o_tick_c ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serving_timer.sv
// Wishbone-attached RISC-V style machine timer: 64-bit mtime/mtimecmp, prescaler, enable and level IRQ.
module serving_timer
  import serving_timer_pkg::*;
#(
  parameter int unsigned            PRESCALE_W = 16,
  parameter logic [PRESCALE_W-1:0]  RESET_PRE  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WB_AW-1:0] i_wb_adr,
  input  logic [WB_DW-1:0] i_wb_dat,
  input  logic [WB_SW-1:0] i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_stb,
  output logic [WB_DW-1:0] o_wb_rdt,
  output logic             o_wb_ack,
  output logic             o_timer_irq
);

  logic [TIME_W-1:0]     mtime_q,  mtime_d;
  logic [TIME_W-1:0]     cmp_q,    cmp_d;
  logic [WB_DW-1:0]      shadow_q, shadow_d;
  logic [WB_DW-1:0]      rdt_q,    rdt_d;
  logic [PRESCALE_W-1:0] pre_q,    pre_d;
  logic                  en_q,     en_d;
  logic                  ack_q,    ack_d;
  logic                  irq_q,    irq_d;

  logic                  access_c;
  logic                  wr_c;
  logic                  rd_c;
  logic                  tick_c;
  logic                  clear_c;
  logic [WB_DW-1:0]      pre_wr_c;

  assign access_c = i_wb_stb & ~ack_q;
  assign wr_c     = access_c & i_wb_we & (|i_wb_sel);
  assign rd_c     = access_c & ~i_wb_we;
  assign clear_c  = wr_c & (i_wb_adr == TMR_PRESCALE);
  assign pre_wr_c = wb_merge(WB_DW'(pre_q), i_wb_dat, i_wb_sel);

  serving_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (en_q),
    .i_reload (pre_q),
    .i_clear  (clear_c),
    .o_tick_c (tick_c)
  );

  // Bus writes to a mtime half replace the tick for that cycle; the other half keeps its old value.
  always_comb begin
    mtime_d  = mtime_q;
    cmp_d    = cmp_q;
    shadow_d = shadow_q;
    rdt_d    = rdt_q;
    pre_d    = pre_q;
    en_d     = en_q;
    ack_d    = access_c;
    irq_d    = (mtime_q >= cmp_q);

    if (tick_c) mtime_d = mtime_q + TIME_W'(1);

    if (rd_c) begin
      unique case (i_wb_adr)
        TMR_MTIME_LO: begin
          rdt_d    = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        TMR_MTIME_HI: rdt_d = shadow_q;
        TMR_CMP_LO:   rdt_d = cmp_q[31:0];
        TMR_CMP_HI:   rdt_d = cmp_q[63:32];
        TMR_CTRL:     rdt_d = WB_DW'(en_q);
        TMR_PRESCALE: rdt_d = WB_DW'(pre_q);
        default:      rdt_d = '0;
      endcase
    end

    if (wr_c) begin
      unique case (i_wb_adr)
        TMR_MTIME_LO: mtime_d = {mtime_q[63:32], wb_merge(mtime_q[31:0], i_wb_dat, i_wb_sel)};
        TMR_MTIME_HI: mtime_d = {wb_merge(mtime_q[63:32], i_wb_dat, i_wb_sel), mtime_q[31:0]};
        TMR_CMP_LO:   cmp_d   = {cmp_q[63:32], wb_merge(cmp_q[31:0], i_wb_dat, i_wb_sel)};
        TMR_CMP_HI:   cmp_d   = {wb_merge(cmp_q[63:32], i_wb_dat, i_wb_sel), cmp_q[31:0]};
        TMR_CTRL:     if (i_wb_sel[0]) en_d = i_wb_dat[TMR_CTRL_EN];
        TMR_PRESCALE: pre_d   = PRESCALE_W'(pre_wr_c);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mtime_q  <= '0;
      cmp_q    <= '1;
      shadow_q <= '0;
      rdt_q    <= '0;
      pre_q    <= RESET_PRE;
      en_q     <= 1'b0;
      ack_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      shadow_q <= shadow_d;
      rdt_q    <= rdt_d;
      pre_q    <= pre_d;
      en_q     <= en_d;
      ack_q    <= ack_d;
      irq_q    <= irq_d;
    end
  end

  assign o_wb_rdt    = rdt_q;
  assign o_wb_ack    = ack_q;
  assign o_timer_irq = irq_q;

endmodule
